// File: rtl/dcm_lock_supervisor_if.sv
// Status/control bundle between the DCM lock supervisor and its environment.
//   master : supervisor side (samples DCM status and requests, drives resets/status)
//   slave  : environment side (DCM model, clock service controller)
// Signals:
//   dcm_locked  DCM LOCKED, asynchronous to the supervisor clock
//   clkin_stop  DCM STATUS[1] (CLKIN stopped), asynchronous
//   req_reset   single-cycle request to restart the DCM sequence
//   clear_fault single-cycle request to leave FAULT and retry
//   dcm_rst     DCM RST drive, active-high
//   rst_out_n   downstream reset, active-low
//   ready       high only while running with a stable lock
//   fault       high only in the fault state
//   retry_cnt   failed attempts in the current sequence
//   unlock_cnt  lock losses seen while running, saturating
interface dcm_lock_supervisor_if;
  logic       dcm_locked;
  logic       clkin_stop;
  logic       req_reset;
  logic       clear_fault;
  logic       dcm_rst;
  logic       rst_out_n;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] unlock_cnt;

  modport master (
    input  dcm_locked, clkin_stop, req_reset, clear_fault,
    output dcm_rst, rst_out_n, ready, fault, retry_cnt, unlock_cnt
  );

  modport slave (
    output dcm_locked, clkin_stop, req_reset, clear_fault,
    input  dcm_rst, rst_out_n, ready, fault, retry_cnt, unlock_cnt
  );
endinterface

// File: rtl/dcm_lock_supervisor.sv
// Sequences the DCM reset/lock cycle and gates the downstream system reset.
// Pulses DCM reset, waits for lock, requires the lock to stay stable before releasing the
// downstream reset, retries on failure and parks in FAULT after repeated failures.
// Must be clocked from the free-running reference clock, never from a DCM output.
// Ports:
//   clk_i   reference clock
//   rst_ni  asynchronous active-low reset
//   bus_io  status/control bundle (see dcm_lock_supervisor_if)
module dcm_lock_supervisor #(
  parameter int unsigned RstCycles    = 4,
  parameter int unsigned LockTimeout  = 1024,
  parameter int unsigned SettleCycles = 64,
  parameter int unsigned MaxRetries   = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  dcm_lock_supervisor_if.master   bus_io
);

  localparam int unsigned MaxRs  = (RstCycles > SettleCycles) ? RstCycles : SettleCycles;
  localparam int unsigned MaxCyc = (LockTimeout > MaxRs) ? LockTimeout : MaxRs;
  localparam int unsigned TimerW = (MaxCyc > 2) ? $clog2(MaxCyc) : 1;

  typedef enum logic [2:0] {StHold, StWait, StSettle, StRun, StFault} state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [3:0]        retry_q, retry_d;
  logic [7:0]        unlock_q, unlock_d;
  logic [1:0]        lock_sync_q, stop_sync_q;
  logic              dcm_rst_q, rst_out_n_q, ready_q, fault_q;
  logic              lk;
  logic              attempt_failed;

  // Lock is only trusted while CLKIN is also running.
  assign lk = lock_sync_q[1] & ~stop_sync_q[1];

  always_comb begin
    state_d        = state_q;
    retry_d        = retry_q;
    unlock_d       = unlock_q;
    attempt_failed = 1'b0;
    unique case (state_q)
      StHold: begin
        if (timer_q == TimerW'(RstCycles - 1)) state_d = StWait;
      end
      StWait: begin
        // Timeout outranks a concurrent restart request so the retry is counted.
        if (lk)                                        state_d = StSettle;
        else if (timer_q == TimerW'(LockTimeout - 1))  attempt_failed = 1'b1;
        else if (bus_io.req_reset)                     state_d = StHold;
      end
      StSettle: begin
        if (!lk)                                        attempt_failed = 1'b1;
        else if (timer_q == TimerW'(SettleCycles - 1))  state_d = StRun;
        else if (bus_io.req_reset)                      state_d = StHold;
      end
      StRun: begin
        // Lock loss and restart request collapse into a single restart.
        if (!lk) begin
          if (unlock_q != 8'hFF) unlock_d = unlock_q + 8'd1;
          state_d = StHold;
        end else if (bus_io.req_reset) begin
          state_d = StHold;
        end
      end
      StFault: begin
        if (bus_io.clear_fault) begin
          retry_d = 4'd0;
          state_d = StHold;
        end
      end
      default: state_d = StHold;
    endcase

    if (attempt_failed) begin
      retry_d = retry_q + 4'd1;
      state_d = (retry_d == 4'(MaxRetries)) ? StFault : StHold;
    end

    if (state_d == StRun && state_q != StRun) retry_d = 4'd0;

    // RUN and FAULT have no terminal count, so the timer rests at zero there.
    if (state_d != state_q || state_d == StRun || state_d == StFault) timer_d = '0;
    else                                                              timer_d = timer_q + TimerW'(1);
  end

  // Outputs are decoded from the next state so they move on the transition edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StHold;
      timer_q     <= '0;
      retry_q     <= 4'd0;
      unlock_q    <= 8'd0;
      lock_sync_q <= 2'b00;
      stop_sync_q <= 2'b00;
      dcm_rst_q   <= 1'b1;
      rst_out_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      unlock_q    <= unlock_d;
      lock_sync_q <= {lock_sync_q[0], bus_io.dcm_locked};
      stop_sync_q <= {stop_sync_q[0], bus_io.clkin_stop};
      dcm_rst_q   <= (state_d == StHold) || (state_d == StFault);
      rst_out_n_q <= (state_d == StRun);
      ready_q     <= (state_d == StRun);
      fault_q     <= (state_d == StFault);
    end
  end

  assign bus_io.dcm_rst    = dcm_rst_q;
  assign bus_io.rst_out_n  = rst_out_n_q;
  assign bus_io.ready      = ready_q;
  assign bus_io.fault      = fault_q;
  assign bus_io.retry_cnt  = retry_q;
  assign bus_io.unlock_cnt = unlock_q;

endmodule
